// File: rtl/ttl_74194_sync_clear_pkg.sv
// Shared definitions for the 7400-series storage models.
// Holds the universal shift register mode encoding and the per-stage next-state select.
package ttl_74194_sync_clear_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // An unknown mode yields X so that a floating select is visible rather than held
  function automatic logic stage_next(
    input logic [1:0] mode,
    input logic       hold_v,
    input logic       shr_v,
    input logic       shl_v,
    input logic       load_v
  );
    case (mode)
      MODE_HOLD: stage_next = hold_v;
      MODE_SHR:  stage_next = shr_v;
      MODE_SHL:  stage_next = shl_v;
      MODE_LOAD: stage_next = load_v;
      default:   stage_next = 1'bx;
    endcase
  endfunction

endpackage

// File: rtl/ttl_74194_sync_clear.sv
// WIDTH-bit universal bidirectional shift register (74194 function set) with
// synchronous active-high clear and separate rise/fall output delays.
module ttl_74194_sync_clear
  import ttl_74194_sync_clear_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned DELAY_RISE = 0,
  parameter int unsigned DELAY_FALL = 0
) (
  input  logic             Clk,
  input  logic             Clear,
  input  logic [1:0]       S,
  input  logic             DSR,
  input  logic             DSL,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] shr_src;
  logic [WIDTH-1:0] shl_src;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  // Neighbour taps: right shift moves toward Q[WIDTH-1], left shift toward Q[0]
  assign shr_src = {q_q[WIDTH-2:0], DSR};
  assign shl_src = {DSL, q_q[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    assign q_d[i] = stage_next(S, q_q[i], shr_src[i], shl_src[i], D[i]);
  end

  always_ff @(posedge Clk) begin
    if (Clear) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Each bit takes the rise-delayed copy while heading high and the
  // fall-delayed copy while heading low, giving distinct edge delays.
  assign #(DELAY_RISE) rise_q = q_q;
  assign #(DELAY_FALL) fall_q = q_q;
  assign Q = (q_q & rise_q) | (~q_q & fall_q);

endmodule

// File: tb/tb_ttl_74194_sync_clear.sv
// Directed test of ttl_74194_sync_clear: modes, clear timing, edge delays and
// a two-instance cascade, all against hand-computed values.
module tb_ttl_74194_sync_clear;

  logic       clk = 1'b0;
  logic       clear;
  logic [1:0] s;
  logic       dsr, dsl;
  logic [3:0] d;
  logic [3:0] q4, qd;

  logic [7:0] d_lo, d_hi, q_lo, q_hi;
  logic       dsr8, dsl8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ttl_74194_sync_clear #(.WIDTH(4)) dut (
    .Clk(clk), .Clear(clear), .S(s), .DSR(dsr), .DSL(dsl), .D(d), .Q(q4)
  );

  ttl_74194_sync_clear #(.WIDTH(4), .DELAY_RISE(3), .DELAY_FALL(5)) dut_dly (
    .Clk(clk), .Clear(clear), .S(s), .DSR(dsr), .DSL(dsl), .D(d), .Q(qd)
  );

  // Cascade: right chain lo.Q[7] -> hi.DSR, left chain hi.Q[0] -> lo.DSL
  ttl_74194_sync_clear #(.WIDTH(8)) dut_lo (
    .Clk(clk), .Clear(clear), .S(s), .DSR(dsr8), .DSL(q_hi[0]), .D(d_lo), .Q(q_lo)
  );

  ttl_74194_sync_clear #(.WIDTH(8)) dut_hi (
    .Clk(clk), .Clear(clear), .S(s), .DSR(q_lo[7]), .DSL(dsl8), .D(d_hi), .Q(q_hi)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] shr_exp [4];
    logic [3:0] shl_exp [4];
    logic [15:0] cas_exp [4];
    shr_exp = '{4'b0101, 4'b1010, 4'b0100, 4'b1000};
    shl_exp = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    cas_exp = '{16'h014B, 16'h0296, 16'h052C, 16'h0A58};

    clear = 1'b1; s = 2'b11; d = 4'b1010; dsr = 1'b0; dsl = 1'b0;
    d_lo = 8'hFF; d_hi = 8'hFF; dsr8 = 1'b0; dsl8 = 1'b0;
    #2;

    // Clear dominates a pending load
    tick();
    check("clear_over_load", {12'b0, q4}, 16'h0000);
    check("clear_cascade", {q_hi, q_lo}, 16'h0000);

    clear = 1'b0;
    tick();
    check("load_1010", {12'b0, q4}, 16'h000A);

    // Shift right from 1010
    s = 2'b01;
    for (int i = 0; i < 4; i++) begin
      dsr = (i == 0);
      tick();
      check($sformatf("shr_%0d", i), {12'b0, q4}, {12'b0, shr_exp[i]});
    end

    // Shift left from 0001 with DSR toggling
    s = 2'b11; d = 4'b0001;
    tick();
    check("load_0001", {12'b0, q4}, 16'h0001);
    s = 2'b10; dsl = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dsr = ~dsr;
      tick();
      check($sformatf("shl_%0d", i), {12'b0, q4}, {12'b0, shl_exp[i]});
    end

    // Hold while everything else toggles
    s = 2'b11; d = 4'b0110;
    tick();
    s = 2'b00;
    for (int i = 0; i < 5; i++) begin
      d = ~d; dsr = ~dsr; dsl = ~dsl;
      tick();
      check($sformatf("hold_%0d", i), {12'b0, q4}, 16'h0006);
    end

    // Clear pulse between edges must not act
    clear = 1'b1;
    #3;
    clear = 1'b0;
    check("clear_glitch_mid", {12'b0, q4}, 16'h0006);
    tick();
    check("clear_glitch_edge", {12'b0, q4}, 16'h0006);

    // Clear mid-shift, then shifting resumes from zero
    s = 2'b01; dsr = 1'b1;
    tick();
    check("shr_pre_clear", {12'b0, q4}, 16'h000D);
    clear = 1'b1;
    tick();
    check("clear_mid_shift", {12'b0, q4}, 16'h0000);
    clear = 1'b0;
    tick();
    check("shr_after_clear", {12'b0, q4}, 16'h0001);

    // Edge delays: rise 3, fall 5
    s = 2'b11; d = 4'b0000;
    tick();
    #10;
    check("dly_base", {12'b0, qd}, 16'h0000);
    d = 4'b1111;
    @(posedge clk);
    #2;
    check("dly_rise_early", {12'b0, qd}, 16'h0000);
    #2;
    check("dly_rise_done", {12'b0, qd}, 16'h000F);
    d = 4'b0000;
    @(posedge clk);
    #4;
    check("dly_fall_early", {12'b0, qd}, 16'h000F);
    #2;
    check("dly_fall_done", {12'b0, qd}, 16'h0000);

    // Cascaded 16-bit chain of two 8-bit stages
    d_lo = 8'hA5; d_hi = 8'h00;
    tick();
    check("cas_load", {q_hi, q_lo}, 16'h00A5);
    s = 2'b01;
    for (int i = 0; i < 4; i++) begin
      dsr8 = (i == 0);
      tick();
      check($sformatf("cas_shr_%0d", i), {q_hi, q_lo}, cas_exp[i]);
    end
    s = 2'b10; dsl8 = 1'b0;
    tick();
    check("cas_shl_0", {q_hi, q_lo}, 16'h052C);
    tick();
    check("cas_shl_1", {q_hi, q_lo}, 16'h0296);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
